// File: rtl/boid_painter.sv
// boid_painter: two-pass rasterizer that erases previous and draws current boid pixels.
// Optional macro BOID_PAINT_CROSS_EN paints a 5-pixel plus per boid instead of one pixel.
module boid_painter #(
  parameter int num_boids = 2,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int FRAC_BITS = 16,
  parameter logic [7:0] BG_COLOR = 8'h00,
  parameter logic [7:0] BOID_COLOR = 8'hFF,
  localparam int IW = (num_boids > 1) ? $clog2(num_boids) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [IW-1:0] which_boid,
  output logic          rd_en,
  input  logic [31:0]   x_in,
  input  logic [31:0]   y_in,
  input  logic [31:0]   px_in,
  input  logic [31:0]   py_in,
  output logic [18:0]   pix_addr,
  output logic [7:0]    pix_data,
  output logic          pix_we,
  input  logic          pix_ready
);

  typedef enum logic [2:0] {
    IDLE, READ, LATCH, WRITE, NEXT, DONE
  } state_t;

  typedef enum logic {ERASE, DRAW} pass_t;

  state_t state, state_n;
  pass_t pass, pass_n;
  logic [IW-1:0] idx, idx_n;
  logic adv, last, pix_inb, wr_step;
  logic signed [31:0] cx, cy, ix, iy;
  logic [7:0] color;

  function automatic logic inb_f(input logic signed [31:0] x,
                                 input logic signed [31:0] y);
    return (x >= 0) && (x < SCREEN_W) && (y >= 0) && (y < SCREEN_H);
  endfunction

  function automatic logic [18:0] addr_f(input logic signed [31:0] x,
                                         input logic signed [31:0] y);
    return 19'(y * SCREEN_W + x);
  endfunction

  // Erase pass reads the old position, draw pass the new one.
  assign cx = (pass == DRAW) ? x_in : px_in;
  assign cy = (pass == DRAW) ? y_in : py_in;
  assign ix = cx >>> FRAC_BITS;
  assign iy = cy >>> FRAC_BITS;
  assign color = (pass == DRAW) ? BOID_COLOR : BG_COLOR;
  assign last = (idx == IW'(num_boids - 1));
  assign wr_step = (state == WRITE) && (!pix_inb || pix_ready);

`ifdef BOID_PAINT_CROSS_EN
  logic signed [31:0] bx_q, by_q, sx, sy;
  logic [2:0] sub;
  logic [7:0] data_q;

  // Latch the boid centre, then walk the five plus offsets.
  always_ff @(posedge clk) begin
    if (reset) begin
      bx_q <= '0;
      by_q <= '0;
      data_q <= '0;
      sub <= '0;
    end else if (state == LATCH) begin
      bx_q <= ix;
      by_q <= iy;
      data_q <= color;
      sub <= '0;
    end else if (wr_step && sub != 3'd4) begin
      sub <= sub + 3'd1;
    end
  end

  // Offset order: centre, left, right, up, down.
  always_comb begin
    sx = bx_q;
    sy = by_q;
    unique case (sub)
      3'd1: sx = bx_q - 32'sd1;
      3'd2: sx = bx_q + 32'sd1;
      3'd3: sy = by_q - 32'sd1;
      3'd4: sy = by_q + 32'sd1;
      default: ;
    endcase
  end

  assign pix_inb = (state == WRITE) && inb_f(sx, sy);
  assign pix_addr = pix_inb ? addr_f(sx, sy) : '0;
  assign pix_data = data_q;
`else
  logic inb_q;
  logic [18:0] addr_q;
  logic [7:0] data_q;

  // Register clip flag, address and colour of the single target pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      inb_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (state == LATCH) begin
      inb_q <= inb_f(ix, iy);
      data_q <= color;
      if (inb_f(ix, iy)) addr_q <= addr_f(ix, iy);
    end
  end

  assign pix_inb = inb_q;
  assign pix_addr = addr_q;
  assign pix_data = data_q;
`endif

  // Sweep state, boid index and pass registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pass <= ERASE;
      idx <= '0;
    end else begin
      state <= state_n;
      pass <= pass_n;
      idx <= idx_n;
    end
  end

  // Next-state logic; adv moves to the next boid, pass or completion.
  always_comb begin
    state_n = state;
    pass_n = pass;
    idx_n = idx;
    adv = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = READ;
          idx_n = '0;
          pass_n = ERASE;
        end
      end
      READ: state_n = LATCH;
      LATCH: state_n = WRITE;
      WRITE: begin
`ifdef BOID_PAINT_CROSS_EN
        if (wr_step && sub == 3'd4) adv = 1'b1;
`else
        if (wr_step) state_n = NEXT;
`endif
      end
      NEXT: adv = 1'b1;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (adv) begin
      if (!last) begin
        idx_n = idx + IW'(1);
        state_n = READ;
      end else if (pass == ERASE) begin
        pass_n = DRAW;
        idx_n = '0;
        state_n = READ;
      end else begin
        state_n = DONE;
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign rd_en = (state == READ);
  assign which_boid = idx;
  assign pix_we = (state == WRITE) && pix_inb;

endmodule

// File: tb/tb_boid_painter.sv
// tb_boid_painter: vector table plus corner sequences for boid_painter.
// Writes are scoreboarded against a queue of expected address/colour pairs.
module tb_boid_painter;

  logic clk = 1'b0;
  logic reset, start, pix_ready;
  logic busy, done, rd_en, pix_we;
  logic [0:0] which_boid;
  logic [31:0] x_in = '0, y_in = '0, px_in = '0, py_in = '0;
  logic [18:0] pix_addr;
  logic [7:0] pix_data;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;

  logic [31:0] mx [2], my [2], mpx [2], mpy [2];
  logic [26:0] q [$];

  typedef struct {
    logic [7:0][31:0] c;
    int n;
    logic [3:0][18:0] a;
    logic [3:0][7:0] d;
  } vec_t;

  vec_t vt [4];

  boid_painter dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .which_boid(which_boid), .rd_en(rd_en),
    .x_in(x_in), .y_in(y_in), .px_in(px_in), .py_in(py_in),
    .pix_addr(pix_addr), .pix_data(pix_data), .pix_we(pix_we),
    .pix_ready(pix_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Boid memory: data valid one cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en) begin
      x_in <= mx[which_boid];
      y_in <= my[which_boid];
      px_in <= mpx[which_boid];
      py_in <= mpy[which_boid];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Accepted writes are popped from the scoreboard.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (pix_we && pix_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_write", {13'd0, pix_addr}, 32'hFFFFFFFF);
      end else begin
        chk("write", {5'd0, pix_addr, pix_data}, {5'd0, q.pop_front()});
      end
    end
  end

  function automatic logic [31:0] fx(input int n);
    return n <<< 16;
  endfunction

  function automatic vec_t mk(
    input logic [31:0] px0, py0, x0, y0, px1, py1, x1, y1,
    input int n,
    input logic [18:0] a0, a1, a2, a3,
    input logic [7:0] d0, d1, d2, d3);
    vec_t v;
    v.c[0] = px0; v.c[1] = py0; v.c[2] = x0; v.c[3] = y0;
    v.c[4] = px1; v.c[5] = py1; v.c[6] = x1; v.c[7] = y1;
    v.n = n;
    v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
    return v;
  endfunction

  task automatic load_push(input vec_t v);
    mpx[0] = v.c[0]; mpy[0] = v.c[1]; mx[0] = v.c[2]; my[0] = v.c[3];
    mpx[1] = v.c[4]; mpy[1] = v.c[5]; mx[1] = v.c[6]; my[1] = v.c[7];
    for (int i = 0; i < v.n; i++) q.push_back({v.a[i], v.d[i]});
  endtask

  // start is high during cycle s; returns at cycle s+1.
  task automatic start_pulse(output int s);
    @(posedge clk); #1;
    start = 1'b1;
    s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // done must be high in cycle s+lat, then busy/done low.
  task automatic wait_done(input int s, input int lat);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 300);
    if (!done) begin
      chk("done_timeout", 32'd0, 32'd1);
    end else begin
      chk("done_latency", cyc - s, lat);
      @(negedge clk);
      chk("done_pulse", {31'd0, done}, 0);
      chk("busy_after", {31'd0, busy}, 0);
    end
  endtask

  task automatic run_vec(input vec_t v, input int lat);
    int s;
    load_push(v);
    start_pulse(s);
    @(negedge clk);
    chk("busy_read", {31'd0, busy}, 1);
    chk("rd_en_read", {31'd0, rd_en}, 1);
    chk("idx_read", {31'd0, which_boid}, 0);
    wait_done(s, lat);
    chk("queue_empty", q.size(), 0);
  endtask

  initial begin
    int s, k, d0;
    logic [18:0] a0;
    logic [7:0] c0;

    vt[0] = mk(fx(5), fx(5), fx(6), fx(5),
               fx(100), fx(200), fx(101), fx(200), 4,
               19'd3205, 19'd128100, 19'd3206, 19'd128101,
               8'h00, 8'h00, 8'hFF, 8'hFF);
    vt[1] = mk(32'h0280_0000, 32'hFFFF_0000, 32'h0280_0000, 32'hFFFF_0000,
               32'h0280_0000, 32'hFFFF_0000, 32'h0280_0000, 32'hFFFF_0000, 0,
               19'd0, 19'd0, 19'd0, 19'd0, 8'h00, 8'h00, 8'h00, 8'h00);
    vt[2] = mk(fx(0), fx(0), fx(639), fx(479),
               fx(-1), fx(0), fx(0), fx(480), 2,
               19'd0, 19'd307199, 19'd0, 19'd0,
               8'h00, 8'hFF, 8'h00, 8'h00);
    vt[3] = mk(32'h0003_8000, 32'h0002_FFFF, 32'hFFFF_8000, 32'h0,
               fx(10), fx(1), 32'h027F_FFFF, 32'h01DF_0000, 3,
               19'd1283, 19'd650, 19'd307199, 19'd0,
               8'h00, 8'h00, 8'hFF, 8'h00);

    reset = 1'b1;
    start = 1'b0;
    pix_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_rd_en", {31'd0, rd_en}, 0);
    chk("rst_we", {31'd0, pix_we}, 0);
    chk("rst_idx", {31'd0, which_boid}, 0);
    chk("rst_addr", {13'd0, pix_addr}, 0);
    chk("rst_data", {24'd0, pix_data}, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 4; i++) run_vec(vt[i], 17);

    // Ten cycles of back-pressure on the first write.
    pix_ready = 1'b0;
    load_push(vt[0]);
    start_pulse(s);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!pix_we && k < 20);
    chk("stall_we_seen", {31'd0, pix_we}, 1);
    chk("stall_addr", {13'd0, pix_addr}, 3205);
    a0 = pix_addr;
    c0 = pix_data;
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      chk("stall_hold", {4'd0, pix_we, pix_addr, pix_data},
          {4'd0, 1'b1, a0, c0});
    end
    @(posedge clk); #1;
    pix_ready = 1'b1;
    @(negedge clk);
    chk("stall_hold", {4'd0, pix_we, pix_addr, pix_data},
        {4'd0, 1'b1, a0, c0});
    wait_done(s, 27);
    chk("queue_empty", q.size(), 0);

    // start while busy and during DONE is ignored.
    d0 = done_cnt;
    load_push(vt[0]);
    start_pulse(s);
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (cyc < s + 17 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    start = 1'b1;
    @(negedge clk);
    chk("redone_done", {31'd0, done}, 1);
    chk("redone_lat", cyc - s, 17);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("ignored_busy", {31'd0, busy}, 0);
    repeat (5) @(negedge clk);
    chk("single_done", done_cnt - d0, 1);
    chk("queue_empty", q.size(), 0);
    run_vec(vt[0], 17);

    // Reset while the last DRAW write is stalled.
    d0 = done_cnt;
    load_push(vt[0]);
    start_pulse(s);
    k = 0;
    while (cyc < s + 12 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    pix_ready = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!pix_we && k < 20);
    chk("rst_mid_addr", {13'd0, pix_addr}, 128101);
    chk("rst_mid_data", {24'd0, pix_data}, 8'hFF);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    pix_ready = 1'b1;
    @(negedge clk);
    chk("rst_mid_we", {31'd0, pix_we}, 0);
    chk("rst_mid_busy", {31'd0, busy}, 0);
    repeat (10) @(negedge clk);
    chk("rst_mid_no_done", done_cnt - d0, 0);
    chk("rst_mid_pending", q.size(), 1);
    q.delete();
    run_vec(vt[0], 17);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/boid_painter.md
Name: boid_painter

Overview:
- Consumer side of the boid state memory: after the accelerator finishes an update sweep, walks every boid slot, reads current and previous positions, and rasterizes them into the VGA M10K frame buffer.
- Pass 1 erases every boid's previous pixel with the background colour; pass 2 draws every boid's current pixel.
  - Two passes ensure a later boid's erase never clobbers an earlier boid's draw.
- Sits between the boid memory wrapper's read port and the frame-buffer write arbiter.

Parameters:
- num_boids, 2, boid slots in memory (≥1)
- SCREEN_W, 640, visible pixel columns
- SCREEN_H, 480, visible pixel rows
- FRAC_BITS, 16, fractional bits of signed fixed-point positions
- BG_COLOR, 8'h00, erase colour
- BOID_COLOR, 8'hFF, draw colour

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request from accelerator control: positions committed
- busy  out  1  high from cycle after accepted start until DONE state exits
- done  out  1  one-cycle pulse at completion
- which_boid  out  $clog2(num_boids)  memory read index
- rd_en  out  1  memory read strobe; data valid exactly 1 cycle later
- x_in, y_in  in  32  current position, signed 16.16
- px_in, py_in  in  32  previous position, signed 16.16
- pix_addr  out  19  frame-buffer word address, row*SCREEN_W+col
- pix_data  out  8  pixel colour
- pix_we  out  1  write request; held with addr/data stable until accepted
- pix_ready  in  1  arbiter accept; write completes on cycle where pix_we && pix_ready

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: state=IDLE; busy=0; done=0; rd_en=0; pix_we=0; which_boid=0; pix_addr=0; pix_data=0; pass=ERASE.
- Reset mid-operation:
  - Abandons the sweep in the same edge, including any pending pix_we.
  - No write issued after reset; done not pulsed.
- FSM states: IDLE, READ, LATCH, WRITE, NEXT, DONE.
- IDLE:
  - start=1 → READ, idx=0, pass=ERASE.
  - start while not IDLE is ignored, neither queued nor counted.
- READ: rd_en=1, which_boid=idx → LATCH.
- LATCH:
  - Capture coordinates: pass ERASE uses px_in/py_in; pass DRAW uses x_in/y_in.
  - ix = coord[31:FRAC_BITS] signed (truncate toward −∞, i.e. arithmetic shift).
  - inb = (0≤ix<SCREEN_W)&&(0≤iy<SCREEN_H).
  - Register addr = iy*SCREEN_W+ix, computed unsigned 19-bit only when inb.
  - → WRITE.
- WRITE:
  - If inb: pix_we=1, pix_data=BG_COLOR (ERASE) or BOID_COLOR (DRAW); stay until pix_ready=1, then → NEXT.
  - If !inb: pix_we=0 for exactly 1 cycle → NEXT. Clipping is silent.
- NEXT:
  - If idx<num_boids-1: idx++ → READ.
  - Else if pass=ERASE: pass=DRAW, idx=0 → READ.
  - Else → DONE.
- DONE: done=1 for this single cycle → IDLE; busy drops the cycle after.
- Latency with pix_ready tied high: 4 cycles per boid per pass; start-to-done = 8*num_boids+1 cycles.
  - start sampled at edge t; done visible in cycle t+8N+1.
- pix_we never asserted for out-of-range coordinates, including negative values and values equal to SCREEN_W/SCREEN_H.
- pix_ready low stretches WRITE indefinitely; addr/data/we must not change while waiting.

Optional Feature:
- Macro BOID_PAINT_CROSS_EN.
- Defined:
  - Each boid paints a 5-pixel plus, in offset order (0,0),(−1,0),(+1,0),(0,−1),(0,+1).
  - WRITE iterates a 3-bit sub-index; each pixel is clipped individually; out-of-bounds sub-pixels take 1 idle cycle.
  - Per-boid-pass cost is 2+5 cycles; start-to-done = 14*num_boids+1.
- Undefined: single pixel as above; sub-index logic absent.

Test Plan:
- N=2; boid0 p=(5,5) c=(6,5), boid1 p=(100,200) c=(101,200) in 16.16, pix_ready=1 → writes in order:
  - addr 3205/00, 128100/00, 3206/FF, 128101/FF
  - done at start+17
- x=0x0280_0000 (640), y=0xFFFF_0000 (−1) both passes → no pix_we; done still at start+17; idle cycles in WRITE.
- pix_ready low 10 cycles on first write → pix_we, pix_addr, pix_data stable for 11 cycles; done delayed by 10.
- start re-pulsed while busy, and again in DONE cycle → ignored, single done.
  - Next start after IDLE accepted.
- reset asserted during second boid's DRAW WRITE with pix_ready=0 → next cycle pix_we=0, busy=0, no done.
  - Fresh start completes normally.
- BOID_PAINT_CROSS_EN, boid at (0,0) draw → (−1,0) and (0,−1) skipped; writes at 0, 1, 640 only.
